// File: rtl/rbz_spi_master_if.sv
`default_nettype none
// ============================================================================
// rbz_spi_master_if : Wishbone slave bundle for the rbzero SPI controller.
// Revision: 1.0
// ============================================================================
interface rbz_spi_master_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/rbz_spi_master.sv
`default_nettype none
// ============================================================================
// rbz_spi_master : Wishbone-programmed mode-0 MSB-first SPI master for rbzero.
// Optional feature macro: RBZ_SPI_AUTOSTART_EN (TXDATA write in IDLE starts).
// Revision: 1.0
// ============================================================================
module rbz_spi_master #(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  rbz_spi_master_if.slave wb,
  output logic            spi_sclk,
  output logic            spi_mosi,
  output logic            spi_ss_n,
  output logic            busy,
  output logic            irq_done
);
  localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [C_DIV_W-1:0]   div_q, div_d;
  logic [4:0]           bit_q, bit_d;
  logic [MAX_BITS-1:0]  shift_q, shift_d;
  logic                 more_q, more_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ss_n_q, ss_n_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;
  logic                 fhold_q, fhold_d;
  logic [MAX_BITS-1:0]  tx_q, tx_d;
  logic [4:0]           len_q, len_d;
  logic                 hold_q, hold_d;
  logic                 ovr_q, ovr_d;
  logic                 ack_q, ack_d;
  logic [31:0]          rdat_q, rdat_d;

  logic        w_req, w_wr, w_rd, w_tx_wr, w_ctrl_wr, w_auto, w_start, w_tick, w_hold;
  logic [4:0]  w_len;
  logic [31:0] w_status;
  logic        w_unused_adr;

`ifdef RBZ_SPI_AUTOSTART_EN
  localparam logic C_AUTO = 1'b1;
  assign w_auto = w_tx_wr && (state_q == S_IDLE);
`else
  localparam logic C_AUTO = 1'b0;
  assign w_auto = 1'b0;
`endif

  assign w_req     = wb.wbs_cyc_i && wb.wbs_stb_i && !ack_q;
  assign w_wr      = w_req && wb.wbs_we_i;
  assign w_rd      = w_req && !wb.wbs_we_i;
  assign w_tx_wr   = w_wr && !wb.wbs_adr_i[2];
  assign w_ctrl_wr = w_wr && wb.wbs_adr_i[2] && (wb.wbs_sel_i[0] || wb.wbs_sel_i[1]);
  assign w_start   = (w_ctrl_wr && wb.wbs_dat_i[8]) || w_auto;
  // A CTRL write carrying START uses its own LEN/HOLD, not the previous ones
  assign w_len     = w_ctrl_wr ? wb.wbs_dat_i[4:0] : len_q;
  assign w_hold    = w_ctrl_wr ? wb.wbs_dat_i[9] : hold_q;
  assign w_tick    = (div_q == C_DIV_LAST);
  assign w_status  = {17'd0, C_AUTO, hold_q, len_q, 5'd0, ovr_q, ~ss_n_q, busy_q};
  assign w_unused_adr = ^{wb.wbs_adr_i[31:3], wb.wbs_adr_i[1:0]};

  always_comb begin
    tx_d   = tx_q;
    len_d  = len_q;
    hold_d = hold_q;
    ovr_d  = ovr_q;
    rdat_d = rdat_q;
    ack_d  = w_req;
    for (int i = 0; i < 4; i++) begin
      if (w_tx_wr && wb.wbs_sel_i[i]) tx_d[8*i +: 8] = wb.wbs_dat_i[8*i +: 8];
    end
    if (w_ctrl_wr) begin
      len_d  = wb.wbs_dat_i[4:0];
      hold_d = wb.wbs_dat_i[9];
      if (wb.wbs_dat_i[10]) ovr_d = 1'b0;
    end
    // Set after the clear so START+OVR_CLR while busy still flags the drop
    if (w_ctrl_wr && wb.wbs_dat_i[8] && (state_q != S_IDLE)) ovr_d = 1'b1;
    if (w_rd) rdat_d = wb.wbs_adr_i[2] ? w_status : tx_q;
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    more_d  = more_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    irq_d   = 1'b0;
    fhold_d = fhold_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (w_start) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          shift_d = tx_d << (5'd31 - w_len);
          mosi_d  = tx_d[w_len];
          bit_d   = w_len;
          fhold_d = w_hold;
        end else if (w_ctrl_wr && wb.wbs_dat_i[11]) begin
          ss_n_d = 1'b1;
        end
      end
      S_SETUP: begin
        div_d = div_q + 1'b1;
        if (w_tick) begin
          div_d   = '0;
          state_d = S_HIGH;
          sclk_d  = 1'b1;
        end
      end
      S_HIGH: begin
        div_d = div_q + 1'b1;
        if (w_tick) begin
          div_d   = '0;
          state_d = S_LOW;
          sclk_d  = 1'b0;
          more_d  = (bit_q != 5'd0);
          if (bit_q != 5'd0) begin
            shift_d = shift_q << 1;
            mosi_d  = shift_q[MAX_BITS-2];
            bit_d   = bit_q - 5'd1;
          end
        end
      end
      S_LOW: begin
        div_d = div_q + 1'b1;
        if (w_tick) begin
          div_d = '0;
          if (more_q) begin
            state_d = S_HIGH;
            sclk_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        div_d = div_q + 1'b1;
        if (w_tick) begin
          div_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          irq_d   = 1'b1;
          mosi_d  = 1'b0;
          if (!fhold_q) ss_n_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      more_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      fhold_q <= 1'b0;
      tx_q    <= '0;
      len_q   <= 5'd31;
      hold_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      more_q  <= more_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      fhold_q <= fhold_d;
      tx_q    <= tx_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign spi_ss_n     = ss_n_q;
  assign busy         = busy_q;
  assign irq_done     = irq_q;
  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = rdat_q;
endmodule
`default_nettype wire
